// File: rtl/upload_pkg.sv
// Shared definitions for the USB CDC upload arbiter: frame markers, FSM states
// and the source-ID map of the cdc_spi producers.
package upload_pkg;

    // Start-of-frame marker bytes, sent ahead of every frame
    localparam logic [7:0] SOF0_BYTE = 8'hAA;
    localparam logic [7:0] SOF1_BYTE = 8'h44;

    // Source IDs of the cdc_spi producers (the requester index doubles as SRC_ID)
    localparam int SRC_UART_RX  = 0;
    localparam int SRC_SPI_RB   = 1;
    localparam int SRC_DAC_STAT = 2;
    localparam int SRC_AUX      = 3;

    // Framer states, in wire order
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF0,
        ST_SOF1,
        ST_ID,
        ST_LENH,
        ST_LENL,
        ST_PAYLOAD,
        ST_CSUM
    } state_t;

    // Running checksum is a plain modulo-256 byte sum
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer,
// wrapping around. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int cand;

    // Scan from the pointer upward and take the first active request
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            if (!any && req[IDX_W'(cand)]) begin
                any                = 1'b1;
                idx                = IDX_W'(cand);
                grant[IDX_W'(cand)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/upload_arbiter.sv
// Round-robin sharing of the USB CDC upload byte stream between producers.
// Each grant produces one frame: AA 44 ID LEN_H LEN_L payload CSUM.
module upload_arbiter
    import upload_pkg::*;
#(
    parameter int         NUM_SRC  = 4,
    parameter int         TIMEOUT  = 1024,
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC-1:0]    src_req,
    input  logic [16*NUM_SRC-1:0] src_len,
    input  logic [8*NUM_SRC-1:0]  src_data,
    input  logic [NUM_SRC-1:0]    src_valid,
    output logic [NUM_SRC-1:0]    src_ready,
    output logic [NUM_SRC-1:0]    src_grant,
    output logic [7:0]            upload_data,
    output logic                  upload_valid,
    input  logic                  upload_ready,
    output logic                  err_timeout
);

    localparam int IDX_W = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   arb_idx;
    logic [NUM_SRC-1:0] arb_grant;
    logic               arb_any;
    logic [15:0]        len_q;
    logic [15:0]        pay_cnt;
    logic [7:0]         csum;
    logic [TO_W-1:0]    to_cnt;
    logic               padding;
    logic               csum_loaded;

    logic               can_load;
    logic [7:0]         sel_data;
    logic               sel_valid;
    logic               take;
    logic               pad_emit;
    logic               timeout_hit;
    logic               last_byte;
    logic               load;
    logic [7:0]         load_byte;
    logic               sum_en;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req   (src_req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // The output register can take a new byte when empty or being drained this cycle
    assign can_load    = !upload_valid || upload_ready;
    assign sel_data    = src_data[{gnt_idx, 3'b000} +: 8];
    assign sel_valid   = src_valid[gnt_idx];
    assign take        = (state == ST_PAYLOAD) && !padding && can_load && sel_valid;
    assign pad_emit    = (state == ST_PAYLOAD) && padding && can_load;
    assign timeout_hit = (state == ST_PAYLOAD) && !padding && !sel_valid
                         && (to_cnt == TO_W'(TIMEOUT));
    assign last_byte   = (pay_cnt == len_q - 16'd1);
    assign src_ready   = ((state == ST_PAYLOAD) && !padding && can_load) ? src_grant : '0;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus which byte (if any) goes into the output register this cycle
    always_comb begin
        next_state = state;
        load       = 1'b0;
        load_byte  = 8'h00;
        sum_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_any) begin
                    next_state = ST_SOF0;
                end
            end
            ST_SOF0: begin
                if (can_load) begin
                    load       = 1'b1;
                    load_byte  = SOF0_BYTE;
                    next_state = ST_SOF1;
                end
            end
            ST_SOF1: begin
                if (can_load) begin
                    load       = 1'b1;
                    load_byte  = SOF1_BYTE;
                    next_state = ST_ID;
                end
            end
            ST_ID: begin
                if (can_load) begin
                    load       = 1'b1;
                    load_byte  = 8'(gnt_idx);
                    sum_en     = 1'b1;
                    next_state = ST_LENH;
                end
            end
            ST_LENH: begin
                if (can_load) begin
                    load       = 1'b1;
                    load_byte  = len_q[15:8];
                    sum_en     = 1'b1;
                    next_state = ST_LENL;
                end
            end
            ST_LENL: begin
                if (can_load) begin
                    load       = 1'b1;
                    load_byte  = len_q[7:0];
                    sum_en     = 1'b1;
                    next_state = (len_q == 16'd0) ? ST_CSUM : ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (take || pad_emit) begin
                    load      = 1'b1;
                    load_byte = take ? sel_data : PAD_BYTE;
                    sum_en    = 1'b1;
                    if (last_byte) begin
                        next_state = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (!csum_loaded && can_load) begin
                    load      = 1'b1;
                    load_byte = csum;
                end else if (csum_loaded && upload_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Output register, grant/pointer, checksum, byte and timeout counters
    always_ff @(posedge clk) begin
        if (rst) begin
            upload_data  <= 8'h00;
            upload_valid <= 1'b0;
            err_timeout  <= 1'b0;
            src_grant    <= '0;
            gnt_idx      <= '0;
            rr_ptr       <= '0;
            len_q        <= 16'd0;
            pay_cnt      <= 16'd0;
            csum         <= 8'h00;
            to_cnt       <= '0;
            padding      <= 1'b0;
            csum_loaded  <= 1'b0;
        end else begin
            err_timeout <= 1'b0;

            if (load) begin
                upload_data  <= load_byte;
                upload_valid <= 1'b1;
            end else if (upload_valid && upload_ready) begin
                upload_valid <= 1'b0;
            end

            if (sum_en) begin
                csum <= csum_add(csum, load_byte);
            end

            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        src_grant   <= arb_grant;
                        gnt_idx     <= arb_idx;
                        len_q       <= src_len[{arb_idx, 4'b0000} +: 16];
                        csum        <= 8'h00;
                        pay_cnt     <= 16'd0;
                        to_cnt      <= '0;
                        padding     <= 1'b0;
                        csum_loaded <= 1'b0;
                    end
                end
                ST_PAYLOAD: begin
                    if (take || pad_emit) begin
                        pay_cnt <= pay_cnt + 16'd1;
                    end
                    if (take) begin
                        to_cnt <= '0;
                    end else if (timeout_hit) begin
                        padding     <= 1'b1;
                        err_timeout <= 1'b1;
                    end else if (!padding && can_load && !sel_valid) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_CSUM: begin
                    if (load) begin
                        csum_loaded <= 1'b1;
                    end
                    if (next_state == ST_IDLE) begin
                        src_grant <= '0;
                        rr_ptr    <= (gnt_idx == IDX_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
